// File: rtl/twos_complement_pkg.sv
// Shared definitions for the shared-negator arbiter: operand width, the
// overflow operand, control states and a reusable round-robin picker.
package twos_complement_pkg;

    localparam int unsigned OPW     = 8;
    localparam logic [7:0]  MIN_NEG = 8'h80;
    localparam int unsigned MAX_REQ = 8;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } arb_state_e;

    // Sized for the widest supported arbiter so every round-robin block can share it;
    // the caller zero-extends its valid vector and pointer and passes its own n.
    // Returns ptr when nothing is valid, so callers must qualify with |valid.
    function automatic logic [2:0] rr_pick(input logic [MAX_REQ-1:0] valid,
                                           input logic [2:0]         ptr,
                                           input int                 n);
        logic [2:0] pick;
        int         idx;
        pick = ptr;
        // Walk offsets from farthest to nearest so the nearest valid index wins.
        for (int k = MAX_REQ - 1; k >= 0; k--) begin
            if (k < n) begin
                idx = (int'(ptr) + k) % n;
                if (valid[idx]) begin
                    pick = 3'(idx);
                end
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/twos_complement.sv
// Combinational 8-bit two's-complement negator: y = (~a + 1) mod 256.
module twos_complement
    import twos_complement_pkg::*;
(
    input  logic [OPW-1:0] a,
    output logic [OPW-1:0] y
);

    assign y = ~a + OPW'(1);

endmodule

// File: rtl/twos_complement_arbiter.sv
// Round-robin arbiter sharing one negator among N_REQ requesters, with a
// single registered valid/ready response slot and a saturating op counter.
module twos_complement_arbiter
    import twos_complement_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [OPW*N_REQ-1:0] req_data,
    output logic [N_REQ-1:0]     req_ready,
    output logic                 resp_valid,
    output logic [OPW-1:0]       resp_data,
    output logic [ID_W-1:0]      resp_id,
    output logic                 resp_ovf,
    input  logic                 resp_ready,
    output logic [CNT_W-1:0]     op_count
);

    arb_state_e       state_q, state_d;
    logic [ID_W-1:0]  ptr_q, ptr_d;
    logic [OPW-1:0]   data_q, data_d;
    logic [ID_W-1:0]  id_q, id_d;
    logic             ovf_q, ovf_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic             can_accept;
    logic             accept;
    logic             consume;
    logic [2:0]       grant_idx;
    logic [ID_W-1:0]  grant_id;
    logic [OPW-1:0]   operand;
    logic [OPW-1:0]   negated;

    assign resp_valid = (state_q == ST_FULL);
    assign resp_data  = data_q;
    assign resp_id    = id_q;
    assign resp_ovf   = ovf_q;
    assign op_count   = count_q;

    assign grant_idx = rr_pick(MAX_REQ'(req_valid), 3'(ptr_q), N_REQ);
    assign grant_id  = ID_W'(grant_idx);
    assign operand   = req_data[grant_id*OPW +: OPW];

    // Reset gates acceptance so no requester sees a grant while rst_n is low.
    assign can_accept = !resp_valid || resp_ready;
    assign accept     = rst_n && can_accept && (|req_valid);
    assign consume    = resp_valid && resp_ready;
    assign req_ready  = accept ? (N_REQ'(1) << grant_id) : '0;

    twos_complement u_neg (
        .a (operand),
        .y (negated)
    );

    // NOTE: every variable gets its hold value before any branch, so no path
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        data_d  = data_q;
        id_d    = id_q;
        ovf_d   = ovf_q;
        count_d = count_q;

        unique case (state_q)
            ST_EMPTY: if (accept)              state_d = ST_FULL;
            ST_FULL:  if (consume && !accept)  state_d = ST_EMPTY;
            default:                           state_d = ST_EMPTY;
        endcase

        if (accept) begin
            data_d = negated;
            id_d   = grant_id;
            ovf_d  = (operand == MIN_NEG);
            ptr_d  = (grant_id == ID_W'(N_REQ - 1)) ? '0 : grant_id + ID_W'(1);
        end

        if (consume && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
            ptr_q   <= '0;
            data_q  <= '0;
            id_q    <= '0;
            ovf_q   <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            data_q  <= data_d;
            id_q    <= id_d;
            ovf_q   <= ovf_d;
            count_q <= count_d;
        end
    end

endmodule

// File: tb/tb_twos_complement_arbiter.sv
// Directed bench for twos_complement_arbiter (N_REQ=4): reset, single request,
// round-robin, back-pressure, arithmetic boundaries and reset mid-operation.
module tb_twos_complement_arbiter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        resp_valid;
    logic [7:0]  resp_data;
    logic [1:0]  resp_id;
    logic        resp_ovf;
    logic        resp_ready;
    logic [15:0] op_count;

    int checks   = 0;
    int failures = 0;

    twos_complement_arbiter #(.N_REQ(4), .ID_W(2), .CNT_W(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_data  (resp_data),
        .resp_id    (resp_id),
        .resp_ovf   (resp_ovf),
        .resp_ready (resp_ready),
        .op_count   (op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Advance past the next rising edge; registered outputs are then settled.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [1:0] rr_id   [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    logic [7:0] rr_data [5] = '{8'hEF, 8'hDE, 8'hCD, 8'hBC, 8'hEF};

    initial begin
        // 1: reset with every requester asking
        rst_n      = 1'b0;
        req_valid  = 4'b1111;
        req_data   = {8'h44, 8'h33, 8'h22, 8'h11};
        resp_ready = 1'b1;
        step();
        step();
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_data",  32'(resp_data),  32'h00);
        check("rst_resp_id",    32'(resp_id),    32'd0);
        check("rst_resp_ovf",   32'(resp_ovf),   32'd0);
        check("rst_op_count",   32'(op_count),   32'd0);
        check("rst_req_ready",  32'(req_ready),  32'h0);
        rst_n = 1'b1;
        #1;
        check("rel_grant0", 32'(req_ready), 32'b0001);
        step();
        check("rel_valid", 32'(resp_valid), 32'd1);
        check("rel_id",    32'(resp_id),    32'd0);
        check("rel_data",  32'(resp_data),  32'hEF);
        req_valid = 4'b0000;
        step();
        check("rel_drain_valid", 32'(resp_valid), 32'd0);
        check("rel_drain_cnt",   32'(op_count),   32'd1);

        // 2: single request from requester 2 (ptr is 1)
        req_valid = 4'b0100;
        req_data  = {8'h00, 8'h05, 8'h00, 8'h00};
        #1;
        check("single_ready", 32'(req_ready), 32'b0100);
        step();
        req_valid = 4'b0000;
        check("single_valid", 32'(resp_valid), 32'd1);
        check("single_data",  32'(resp_data),  32'hFB);
        check("single_id",    32'(resp_id),    32'd2);
        check("single_ovf",   32'(resp_ovf),   32'd0);
        step();
        check("single_cnt",   32'(op_count),   32'd2);
        check("single_empty", 32'(resp_valid), 32'd0);

        // 3: round-robin from ptr 0 with all requesters held valid
        rst_n = 1'b0;
        step();
        rst_n     = 1'b1;
        req_valid = 4'b1111;
        req_data  = {8'h44, 8'h33, 8'h22, 8'h11};
        for (int i = 0; i < 5; i++) begin
            #1;
            check($sformatf("rr_ready_%0d", i), 32'(req_ready), 32'(4'b0001 << rr_id[i]));
            step();
            check($sformatf("rr_valid_%0d", i), 32'(resp_valid), 32'd1);
            check($sformatf("rr_id_%0d", i),    32'(resp_id),    32'(rr_id[i]));
            check($sformatf("rr_data_%0d", i),  32'(resp_data),  32'(rr_data[i]));
        end
        check("rr_cnt", 32'(op_count), 32'd4);

        // 4: back-pressure holds the pending result and blocks grants
        resp_ready = 1'b0;
        #1;
        check("bp_ready_blocked", 32'(req_ready), 32'h0);
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("bp_valid_%0d", i), 32'(resp_valid), 32'd1);
            check($sformatf("bp_data_%0d", i),  32'(resp_data),  32'hEF);
            check($sformatf("bp_id_%0d", i),    32'(resp_id),    32'd0);
            check($sformatf("bp_ready_%0d", i), 32'(req_ready),  32'h0);
        end
        check("bp_cnt_hold", 32'(op_count), 32'd4);
        resp_ready = 1'b1;
        #1;
        check("bp_release_ready", 32'(req_ready), 32'b0010);
        step();
        check("bp_new_id",   32'(resp_id),   32'd1);
        check("bp_new_data", 32'(resp_data), 32'hDE);
        check("bp_cnt",      32'(op_count),  32'd5);

        // 5: arithmetic boundaries, one lane at a time
        req_data  = {8'hFF, 8'h7F, 8'h00, 8'h80};
        req_valid = 4'b0001;
        step();
        check("bnd80_data", 32'(resp_data), 32'h80);
        check("bnd80_ovf",  32'(resp_ovf),  32'd1);
        check("bnd80_id",   32'(resp_id),   32'd0);
        req_valid = 4'b0010;
        step();
        check("bnd00_data", 32'(resp_data), 32'h00);
        check("bnd00_ovf",  32'(resp_ovf),  32'd0);
        req_valid = 4'b0100;
        step();
        check("bnd7f_data", 32'(resp_data), 32'h81);
        check("bnd7f_ovf",  32'(resp_ovf),  32'd0);
        req_valid = 4'b1000;
        step();
        check("bndff_data", 32'(resp_data), 32'h01);
        check("bndff_ovf",  32'(resp_ovf),  32'd0);
        check("bnd_cnt",    32'(op_count),  32'd9);

        // 6: reset while a result is stalled; ptr is 2 going in
        req_valid = 4'b0010;
        step();
        check("mid_pre_id",  32'(resp_id),  32'd1);
        check("mid_pre_cnt", 32'(op_count), 32'd10);
        req_valid  = 4'b1111;
        resp_ready = 1'b0;
        #1;
        check("mid_stall_ready", 32'(req_ready), 32'h0);
        rst_n = 1'b0;
        step();
        check("mid_rst_valid", 32'(resp_valid), 32'd0);
        check("mid_rst_cnt",   32'(op_count),   32'd0);
        check("mid_rst_data",  32'(resp_data),  32'h00);
        check("mid_rst_ready", 32'(req_ready),  32'h0);
        rst_n      = 1'b1;
        req_valid  = 4'b0000;
        resp_ready = 1'b1;
        step();
        check("mid_no_ghost", 32'(resp_valid), 32'd0);
        check("mid_no_count", 32'(op_count),   32'd0);
        req_valid = 4'b1111;
        #1;
        check("mid_ptr0", 32'(req_ready), 32'b0001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
